// File: rtl/core_obi2axi_bridge_pkg.sv
// Shared types and constants for the OBI-to-AXI4 single-beat bridge.
// Includes the bridge FSM states and the packed bus structs used by the wrapper.
package core_obi2axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int CORE_ADDR_W   = 32;
  localparam int CORE_DATA_W   = 32;
  localparam int CORE_STRB_W   = CORE_DATA_W / 8;
  localparam int AXI_DATA_ID_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_BWAIT,
    ST_RD,
    ST_RWAIT,
    ST_RESP
  } obi2axi_state_e;

  typedef struct packed {
    logic                   req;
    logic [CORE_ADDR_W-1:0] addr;
    logic                   we;
    logic [CORE_STRB_W-1:0] be;
    logic [CORE_DATA_W-1:0] wdata;
  } core_data_req_t;

  typedef struct packed {
    logic                   gnt;
    logic                   rvalid;
    logic [CORE_DATA_W-1:0] rdata;
    logic                   err;
  } core_data_rsp_t;

  typedef struct packed {
    logic                     aw_valid;
    logic [CORE_ADDR_W-1:0]   aw_addr;
    logic [AXI_DATA_ID_W-1:0] aw_id;
    logic [7:0]               aw_len;
    logic [2:0]               aw_size;
    logic [1:0]               aw_burst;
    logic                     w_valid;
    logic [CORE_DATA_W-1:0]   w_data;
    logic [CORE_STRB_W-1:0]   w_strb;
    logic                     w_last;
    logic                     b_ready;
    logic                     ar_valid;
    logic [CORE_ADDR_W-1:0]   ar_addr;
    logic [AXI_DATA_ID_W-1:0] ar_id;
    logic [7:0]               ar_len;
    logic [2:0]               ar_size;
    logic [1:0]               ar_burst;
    logic                     r_ready;
  } core_axi_data_req_t;

  typedef struct packed {
    logic                   aw_ready;
    logic                   w_ready;
    logic                   b_valid;
    logic [1:0]             b_resp;
    logic                   ar_ready;
    logic                   r_valid;
    logic [CORE_DATA_W-1:0] r_data;
    logic [1:0]             r_resp;
    logic                   r_last;
  } core_axi_data_rsp_t;

endpackage

// File: rtl/core_obi2axi_bridge_wrap.sv
// Struct-port wrapper around the flat bridge, matching the tile's OBI/AXI bus typedefs.
module core_obi2axi_bridge_wrap
  import core_obi2axi_bridge_pkg::*;
#(
  parameter int AXI_ID = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  core_data_req_t     obi_req_i,
  output core_data_rsp_t     obi_rsp_o,
  output core_axi_data_req_t axi_req_o,
  input  core_axi_data_rsp_t axi_rsp_i
);

  core_obi2axi_bridge #(
    .ADDR_W   (CORE_ADDR_W),
    .DATA_W   (CORE_DATA_W),
    .STRB_W   (CORE_STRB_W),
    .AXI_ID_W (AXI_DATA_ID_W),
    .AXI_ID   (AXI_ID)
  ) u_core (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req_i.req),
    .obi_gnt_o    (obi_rsp_o.gnt),
    .obi_addr_i   (obi_req_i.addr),
    .obi_we_i     (obi_req_i.we),
    .obi_be_i     (obi_req_i.be),
    .obi_wdata_i  (obi_req_i.wdata),
    .obi_rvalid_o (obi_rsp_o.rvalid),
    .obi_rdata_o  (obi_rsp_o.rdata),
    .obi_err_o    (obi_rsp_o.err),
    .aw_valid_o   (axi_req_o.aw_valid),
    .aw_ready_i   (axi_rsp_i.aw_ready),
    .aw_addr_o    (axi_req_o.aw_addr),
    .aw_id_o      (axi_req_o.aw_id),
    .aw_len_o     (axi_req_o.aw_len),
    .aw_size_o    (axi_req_o.aw_size),
    .aw_burst_o   (axi_req_o.aw_burst),
    .w_valid_o    (axi_req_o.w_valid),
    .w_ready_i    (axi_rsp_i.w_ready),
    .w_data_o     (axi_req_o.w_data),
    .w_strb_o     (axi_req_o.w_strb),
    .w_last_o     (axi_req_o.w_last),
    .b_valid_i    (axi_rsp_i.b_valid),
    .b_ready_o    (axi_req_o.b_ready),
    .b_resp_i     (axi_rsp_i.b_resp),
    .ar_valid_o   (axi_req_o.ar_valid),
    .ar_ready_i   (axi_rsp_i.ar_ready),
    .ar_addr_o    (axi_req_o.ar_addr),
    .ar_id_o      (axi_req_o.ar_id),
    .ar_len_o     (axi_req_o.ar_len),
    .ar_size_o    (axi_req_o.ar_size),
    .ar_burst_o   (axi_req_o.ar_burst),
    .r_valid_i    (axi_rsp_i.r_valid),
    .r_ready_o    (axi_req_o.r_ready),
    .r_data_i     (axi_rsp_i.r_data),
    .r_resp_i     (axi_rsp_i.r_resp),
    .r_last_i     (axi_rsp_i.r_last)
  );

endmodule

// File: rtl/core_obi2axi_bridge.sv
// OBI data-port to AXI4 bridge: one outstanding single-beat transaction at a time.
// Payload outputs come straight from holding registers; valids/readies follow the FSM state.
module core_obi2axi_bridge
  import core_obi2axi_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int AXI_ID_W = 2,
  parameter int AXI_ID   = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                obi_req_i,
  output logic                obi_gnt_o,
  input  logic [ADDR_W-1:0]   obi_addr_i,
  input  logic                obi_we_i,
  input  logic [STRB_W-1:0]   obi_be_i,
  input  logic [DATA_W-1:0]   obi_wdata_i,
  output logic                obi_rvalid_o,
  output logic [DATA_W-1:0]   obi_rdata_o,
  output logic                obi_err_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output logic [ADDR_W-1:0]   aw_addr_o,
  output logic [AXI_ID_W-1:0] aw_id_o,
  output logic [7:0]          aw_len_o,
  output logic [2:0]          aw_size_o,
  output logic [1:0]          aw_burst_o,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [DATA_W-1:0]   w_data_o,
  output logic [STRB_W-1:0]   w_strb_o,
  output logic                w_last_o,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [1:0]          b_resp_i,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output logic [ADDR_W-1:0]   ar_addr_o,
  output logic [AXI_ID_W-1:0] ar_id_o,
  output logic [7:0]          ar_len_o,
  output logic [2:0]          ar_size_o,
  output logic [1:0]          ar_burst_o,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [DATA_W-1:0]   r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic                r_last_i
);

  localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_W));

  obi2axi_state_e r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [STRB_W-1:0] r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_aw_done;
  logic              r_w_done;
  logic              w_unused;

  // Only bit 1 of a response distinguishes error classes; r_last is implied by len = 0.
  assign w_unused = ^{r_last_i, b_resp_i[0], r_resp_i[0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    obi_gnt_o    = 1'b0;
    obi_rvalid_o = 1'b0;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    b_ready_o    = 1'b0;
    ar_valid_o   = 1'b0;
    r_ready_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        obi_gnt_o = obi_req_i;
        if (obi_req_i) w_next = obi_we_i ? ST_WR : ST_RD;
      end
      ST_WR: begin
        aw_valid_o = !r_aw_done;
        w_valid_o  = !r_w_done;
        if ((r_aw_done || aw_ready_i) && (r_w_done || w_ready_i)) w_next = ST_BWAIT;
      end
      ST_BWAIT: begin
        b_ready_o = 1'b1;
        if (b_valid_i) w_next = ST_RESP;
      end
      ST_RD: begin
        ar_valid_o = 1'b1;
        if (ar_ready_i) w_next = ST_RWAIT;
      end
      ST_RWAIT: begin
        r_ready_o = 1'b1;
        if (r_valid_i) w_next = ST_RESP;
      end
      ST_RESP: begin
        obi_rvalid_o = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (obi_req_i) begin
            r_addr    <= {obi_addr_i[ADDR_W-1:2], 2'b00};
            r_be      <= obi_be_i;
            r_wdata   <= obi_wdata_i;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        ST_WR: begin
          if (aw_valid_o && aw_ready_i) r_aw_done <= 1'b1;
          if (w_valid_o && w_ready_i)   r_w_done  <= 1'b1;
        end
        ST_BWAIT: begin
          if (b_valid_i) begin
            r_err   <= b_resp_i[1];
            r_rdata <= '0;
          end
        end
        ST_RWAIT: begin
          if (r_valid_i) begin
            r_err   <= r_resp_i[1];
            r_rdata <= r_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign obi_rdata_o = r_rdata;
  assign obi_err_o   = r_err;

  assign aw_addr_o  = r_addr;
  assign aw_id_o    = AXI_ID_W'(AXI_ID);
  assign aw_len_o   = 8'd0;
  assign aw_size_o  = AXI_SIZE;
  assign aw_burst_o = AXI_BURST_INCR;

  assign w_data_o = r_wdata;
  assign w_strb_o = r_be;
  assign w_last_o = 1'b1;

  assign ar_addr_o  = r_addr;
  assign ar_id_o    = AXI_ID_W'(AXI_ID);
  assign ar_len_o   = 8'd0;
  assign ar_size_o  = AXI_SIZE;
  assign ar_burst_o = AXI_BURST_INCR;

endmodule

// File: tb/tb_core_obi2axi_bridge.sv
// Testbench for core_obi2axi_bridge: directed and randomized single transactions against
// a transaction-level model (address alignment, fixed attributes, response mapping, latency).
module tb_core_obi2axi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req_i, obi_gnt_o, obi_we_i;
  logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o;
  logic [3:0]  obi_be_i;
  logic        obi_rvalid_o, obi_err_o;
  logic        aw_valid_o, aw_ready_i;
  logic [31:0] aw_addr_o;
  logic [1:0]  aw_id_o, aw_burst_o;
  logic [7:0]  aw_len_o;
  logic [2:0]  aw_size_o;
  logic        w_valid_o, w_ready_i, w_last_o;
  logic [31:0] w_data_o;
  logic [3:0]  w_strb_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic        ar_valid_o, ar_ready_i;
  logic [31:0] ar_addr_o;
  logic [1:0]  ar_id_o, ar_burst_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic        r_valid_i, r_ready_o, r_last_i;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;

  int checks = 0;
  int errors = 0;

  core_obi2axi_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
    .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
    .obi_rvalid_o(obi_rvalid_o), .obi_rdata_o(obi_rdata_o), .obi_err_o(obi_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clearSlave();
    aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
    b_valid_i  = 1'b0; r_valid_i = 1'b0;
    b_resp_i   = 2'b00; r_resp_i = 2'b00; r_data_i = 32'h0; r_last_i = 1'b1;
  endtask

  // dly1 = AW/AR ready delay, dly2 = W ready delay, rspDly = extra cycles before B/R.
  // Expected rvalid cycle (grant = cycle 0) = 3 + address-phase wait + response wait.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input int dly1, input int dly2,
                               input int rspDly, input logic [1:0] resp, input logic [31:0] rdata,
                               input logic hold, input logic [31:0] holdAddr);
    int hand, rspAt, expLat, awN, wN, bN, arN, rN;
    logic done;
    logic [31:0] expAddr;
    expAddr = addr & 32'hFFFF_FFFC;
    hand    = (we && dly2 > dly1) ? dly2 : dly1;
    rspAt   = 2 + hand + rspDly;
    expLat  = rspAt + 1;
    awN = 0; wN = 0; bN = 0; arN = 0; rN = 0;
    done = 1'b0;

    @(negedge clk_i);
    obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = addr; obi_be_i = be; obi_wdata_i = wdata;
    #1;
    checkOutput("rvalid_idle", 64'(obi_rvalid_o), 64'd0);
    checkOutput("gnt_idle", 64'(obi_gnt_o), 64'd1);

    @(negedge clk_i);
    if (hold) begin
      obi_we_i = 1'b0; obi_addr_i = holdAddr;
    end else begin
      obi_req_i = 1'b0;
    end
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk_i);
      aw_ready_i = (cyc >= 1 + dly1);
      ar_ready_i = (cyc >= 1 + dly1);
      w_ready_i  = (cyc >= 1 + dly2);
      b_valid_i  = we && (cyc >= rspAt) && (bN == 0);
      r_valid_i  = !we && (cyc >= rspAt) && (rN == 0);
      b_resp_i   = resp; r_resp_i = resp; r_data_i = rdata; r_last_i = 1'b1;
      #1;
      checkOutput("gnt_busy", 64'(obi_gnt_o), 64'd0);
      if (aw_valid_o) begin
        checkOutput("aw_payload", 64'({aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, aw_id_o}),
                    64'({expAddr, 8'd0, 3'd2, 2'b01, 2'd0}));
        if (aw_ready_i) awN++;
      end
      if (w_valid_o) begin
        checkOutput("w_payload", 64'({w_data_o, w_strb_o, w_last_o}), 64'({wdata, be, 1'b1}));
        if (w_ready_i) wN++;
      end
      if (ar_valid_o) begin
        checkOutput("ar_payload", 64'({ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, ar_id_o}),
                    64'({expAddr, 8'd0, 3'd2, 2'b01, 2'd0}));
        if (ar_ready_i) arN++;
      end
      if (b_valid_i && b_ready_o) bN++;
      if (r_valid_i && r_ready_o) rN++;
      if (obi_rvalid_o) begin
        checkOutput("rsp_latency", 64'(cyc), 64'(expLat));
        checkOutput("rsp_rdata", 64'(obi_rdata_o), 64'(we ? 32'h0 : rdata));
        checkOutput("rsp_err", 64'(obi_err_o), 64'(resp[1]));
        done = 1'b1;
      end
    end
    if (!done) checkOutput("rsp_timeout", 64'd0, 64'd1);
    checkOutput("hs_counts", 64'({awN[3:0], wN[3:0], bN[3:0], arN[3:0], rN[3:0]}),
                we ? 64'h11100 : 64'h00011);
    clearSlave();
  endtask

  initial begin
    logic        rwe;
    logic [31:0] raddr;
    rst_ni = 1'b0;
    obi_req_i = 1'b0; obi_we_i = 1'b0; obi_addr_i = 32'h0; obi_be_i = 4'h0; obi_wdata_i = 32'h0;
    clearSlave();
    #12;
    checkOutput("reset_outs", 64'({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o, aw_valid_o,
                w_valid_o, b_ready_o, ar_valid_o, r_ready_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    applyStimulus(1'b0, 32'h2000_0104, 4'hF, 32'h0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h2000_0200, 4'b0011, 32'hCAFE_F00D, 0, 3, 0, 2'b00, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h2000_0008, 4'hF, 32'h0, 0, 0, 0, 2'b10, 32'h1234_5678, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h2000_000C, 4'hF, 32'h5555_AAAA, 0, 0, 0, 2'b11, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h2000_0040, 4'hF, 32'h0, 5, 0, 0, 2'b00, 32'h0BAD_CAFE, 1'b1, 32'h2000_0080);
    applyStimulus(1'b0, 32'h2000_0080, 4'hF, 32'h0, 0, 0, 0, 2'b01, 32'h8765_4321, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h2000_0003, 4'b0000, 32'h0F0F_0F0F, 2, 0, 1, 2'b01, 32'h0, 1'b0, 32'h0);

    // Reset while waiting on R: everything must collapse without waiting for a clock.
    @(negedge clk_i);
    obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h2000_0300;
    @(negedge clk_i);
    obi_req_i = 1'b0; ar_ready_i = 1'b1;
    @(negedge clk_i);
    ar_ready_i = 1'b0;
    #1;
    checkOutput("rwait_ready", 64'(r_ready_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("reset_mid_outs", 64'({obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o, aw_valid_o,
                w_valid_o, b_ready_o, ar_valid_o, r_ready_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1'b0, 32'h2000_0304, 4'hF, 32'h0, 1, 0, 2, 2'b00, 32'hA5A5_5A5A, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
      applyStimulus(rwe, raddr, 4'($urandom), $urandom, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    2'($urandom), $urandom, 1'b0, 32'h0);
    end

    @(negedge clk_i);
    #1;
    checkOutput("rvalid_final", 64'(obi_rvalid_o), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_obi2axi_bridge.md
Name: core_obi2axi_bridge

Overview:
- Converts the core's OBI data-port transactions routed to the L2 window (0x2000_0000–0x2FFF_FFFF) into single-beat AXI4 transactions toward the tile AXI crossbar.
- Sits downstream of the core OBI data crossbar, on the AXI-XBAR slave leg, and upstream of the core AXI data master port.
- Allows one outstanding transaction, i.e. N_MAX_TRAN = 1.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8
AXI_ID_W, 2, AXI ID width (AXI_DATA_ID_W)
AXI_ID, 0, constant ID driven on AW/AR (core = 0)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
obi_req_i / obi_gnt_o  in/out  1/1  OBI A-channel handshake
obi_addr_i  in  ADDR_W  byte address
obi_we_i  in  1  1 = write
obi_be_i  in  STRB_W  byte enables
obi_wdata_i  in  DATA_W  write data
obi_rvalid_o  out  1  response valid (OBI has no rready)
obi_rdata_o  out  DATA_W  read data
obi_err_o  out  1  bus error
aw_valid_o / aw_ready_i  out/in  1/1  AW handshake
aw_addr_o, aw_id_o  out  ADDR_W, AXI_ID_W  write address and ID
aw_len_o, aw_size_o, aw_burst_o  out  8, 3, 2  burst attributes
w_valid_o / w_ready_i  out/in  1/1  W handshake
w_data_o, w_strb_o, w_last_o  out  DATA_W, STRB_W, 1  write beat
b_valid_i / b_ready_o  in/out  1/1  B handshake; b_resp_i  in  2
ar_valid_o / ar_ready_i  out/in  1/1  AR handshake
ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o  out  as AW  read address and attributes
r_valid_i / r_ready_o  in/out  1/1  R handshake; r_data_i  in  DATA_W; r_resp_i  in  2; r_last_i  in  1

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: all valid and ready outputs 0, obi_gnt_o 0, obi_rvalid_o 0, obi_rdata_o 0, obi_err_o 0, FSM in IDLE, holding registers 0.
- FSM states: IDLE, WR, BWAIT, RD, RWAIT, RESP.
- IDLE:
  - obi_gnt_o = obi_req_i (combinational).
  - On req & gnt, register addr with [1:0] forced to 0, be, wdata and we.
  - Go to WR if we = 1, otherwise RD.
- WR:
  - aw_valid_o and w_valid_o both asserted from the first WR cycle; they handshake independently.
  - Each valid drops on its own handshake and is tracked by an aw_done/w_done flag.
  - Go to BWAIT once both handshakes have completed; same-cycle completion goes directly.
  - Valid and payload stay stable until handshake (AXI rule).
- BWAIT: b_ready_o = 1. On b_valid_i, latch err = b_resp_i[1], set rdata = 0, go to RESP.
- RD: ar_valid_o = 1 until ar_ready_i, then go to RWAIT.
- RWAIT: r_ready_o = 1. On r_valid_i, latch r_data_i and err = r_resp_i[1], go to RESP. r_last_i is ignored (always 1 for len = 0).
- RESP: obi_rvalid_o = 1 for exactly one cycle with the latched rdata/err, then return to IDLE.
- obi_gnt_o = 0 in every state other than IDLE.
- Fixed AXI attributes: len = 0, size = $clog2(STRB_W) (= 2), burst = INCR (2'b01), w_last_o = 1, w_strb_o = registered be, id = AXI_ID. All payload outputs are registered.
- Latency with zero-wait slaves:
  - Read: grant in cycle 0, AR handshake in cycle 1, R in cycle 2, obi_rvalid_o in cycle 3.
  - Write: same timing, with AW and W in cycle 1 and B in cycle 2.
  - Next grant no earlier than cycle 4.
- Responses: OKAY and EXOKAY give err = 0; SLVERR and DECERR give err = 1.
- be = 0 write: still issued on AXI, with strobe 0.
- Reset mid-transaction: FSM returns to IDLE immediately and all valids drop. The AXI fabric is reset by the same reset, so no drain is performed.

Decomposition:
- Types come from redmule_tile_pkg: core_data_req_t/rsp_t and core_axi_data_req_t/rsp_t.
- A thin wrapper core_obi2axi_bridge_wrap packs and unpacks these structs onto the flat ports.
- Add to the package: localparams AXI_BURST_INCR = 2'b01 and AXI_RESP_OKAY = 2'b00.
- Add to the package: enum typedef obi2axi_state_e.
- No sub-module; the flat core is a single FSM.

Test Plan:
- Read, zero-wait slave: req addr 0x2000_0104 we = 0 → ar_addr_o = 0x2000_0104, size 2, len 0. Slave r_data 0xDEAD_BEEF OKAY → obi_rvalid_o in cycle 3, rdata 0xDEAD_BEEF, err 0.
- Write with AW and W skewed: aw_ready_i high at cycle 1, w_ready_i delayed to cycle 4, be = 4'b0011 → w_strb_o = 0011 and w_data stable until cycle 4. B OKAY → one rvalid cycle, rdata 0.
- Error: read returns r_resp_i = 2'b10 → obi_err_o = 1. Write returns b_resp_i = 2'b11 → obi_err_o = 1.
- Backpressure: ar_ready_i low for 5 cycles while a second obi_req_i is held → ar_addr_o stable, gnt stays 0 until after RESP, second request granted in the following IDLE.
- Unaligned address 0x2000_0003 → aw_addr_o = 0x2000_0000.
- Reset asserted during RWAIT → all outputs 0 asynchronously. After release, a new read completes normally.
